// File: rtl/pht_update_queue_pkg.sv
// Fetch-unit shared types for the PHT update path: branch result record,
// PHT index/entry types, queue entry record and the update-index hash.
package FetchUnitTypes;

    localparam int INSN_ADDR_BIT_WIDTH             = 2;
    localparam int PC_BIT_WIDTH                    = 32;
    localparam int PHT_ENTRY_NUM_BIT_WIDTH         = 10;
    localparam int BRANCH_GLOBAL_HISTORY_BIT_WIDTH = 10;
    localparam int PHT_ENTRY_BIT_WIDTH             = 2;
    localparam int PHT_QUEUE_SIZE                  = 32;

    typedef logic [PC_BIT_WIDTH-1:0]                    PC_Path;
    typedef logic [BRANCH_GLOBAL_HISTORY_BIT_WIDTH-1:0] BranchGlobalHistoryPath;
    typedef logic [PHT_ENTRY_NUM_BIT_WIDTH-1:0]         PHT_IndexPath;
    typedef logic [PHT_ENTRY_BIT_WIDTH-1:0]             PHT_EntryPath;

    // Strongly-taken saturation point of the 2-bit counter.
    localparam PHT_EntryPath PHT_ENTRY_MAX = 2'd3;

    // Resolved branch as reported by the integer backend.
    typedef struct packed {
        logic                   valid;
        logic                   isCondBr;
        PC_Path                 brAddr;
        logic                   execTaken;
        BranchGlobalHistoryPath globalHistory;
        PHT_EntryPath           phtPrevValue;
    } BranchResult;

    // One pending PHT write.
    typedef struct packed {
        PHT_IndexPath index;
        PHT_EntryPath value;
    } PhtUpdateEntry;

    // gshare index: word-aligned PC bits XOR zero-extended global history.
    function automatic PHT_IndexPath ToPHT_UpdateIndex(PC_Path addr, BranchGlobalHistoryPath gh);
        return addr[PHT_ENTRY_NUM_BIT_WIDTH+INSN_ADDR_BIT_WIDTH-1:INSN_ADDR_BIT_WIDTH]
               ^ PHT_IndexPath'(gh);
    endfunction

endpackage

// File: rtl/pht_update_queue_counter.sv
// Combinational 2-bit saturating counter step used to form the PHT write value.
module pht_counter_update
    import FetchUnitTypes::*;
(
    input  PHT_EntryPath prev,
    input  logic         taken,
    output PHT_EntryPath next
);

    // Increment toward PHT_ENTRY_MAX on taken, decrement toward zero otherwise.
    always_comb begin
        next = prev;
        if (taken) begin
            if (prev == PHT_ENTRY_MAX) begin
                next = PHT_ENTRY_MAX;
            end else begin
                next = prev + 2'd1;
            end
        end else begin
            if (prev == 2'd0) begin
                next = 2'd0;
            end else begin
                next = prev - 2'd1;
            end
        end
    end

endmodule

// File: rtl/pht_update_queue.sv
// PHT update queue: buffers conditional-branch counter updates and writes them
// into the single-ported PHT on cycles the fetch side is not reading it.
// Optional feature macro: RSD_PHT_QUEUE_COALESCE_EN -- merges an update into the
// newest queued entry when both target the same PHT index.
module pht_update_queue
    import FetchUnitTypes::*;
#(
    parameter int QUEUE_SIZE = PHT_QUEUE_SIZE
)(
    input  logic         clk,
    input  logic         rst,
    input  BranchResult  brResult,
    input  logic         phtReadBusy,
    output logic         phtWE,
    output PHT_IndexPath phtWA,
    output PHT_EntryPath phtWV,
    output logic         full,
    output logic         empty,
    output logic         dropped
);

    localparam int PTR_W = $clog2(QUEUE_SIZE);
    localparam int CNT_W = PTR_W + 1;

    typedef logic [PTR_W-1:0] QueuePtr;
    typedef logic [CNT_W-1:0] QueueCount;

    localparam QueueCount CNT_MAX  = QueueCount'(QUEUE_SIZE);
    localparam QueueCount CNT_ZERO = {CNT_W{1'b0}};
    localparam QueueCount CNT_ONE  = QueueCount'(1);
    localparam QueuePtr   PTR_ZERO = {PTR_W{1'b0}};
    localparam QueuePtr   PTR_ONE  = QueuePtr'(1);

    PhtUpdateEntry entryArray_r [QUEUE_SIZE];
    QueuePtr       headPtr_r;
    QueuePtr       tailPtr_r;
    QueueCount     count_r;

    logic          eligible_s;
    logic          pop_s;
    logic          push_s;
    logic          coalesce_s;
    logic          drop_s;
    logic          full_s;
    logic          empty_s;
    PHT_IndexPath  pushIndex_s;
    PHT_EntryPath  pushValue_s;

    assign pushIndex_s = ToPHT_UpdateIndex(brResult.brAddr, brResult.globalHistory);

    pht_counter_update counterUpdate (
        .prev  (brResult.phtPrevValue),
        .taken (brResult.execTaken),
        .next  (pushValue_s)
    );

`ifdef RSD_PHT_QUEUE_COALESCE_EN
    QueuePtr newestPtr_s;
    assign newestPtr_s = tailPtr_r - PTR_ONE;
`endif

    // Queue control: eligibility, pop on free PHT port, push/coalesce/drop decision.
    always_comb begin
        empty_s    = (count_r == CNT_ZERO);
        full_s     = (count_r == CNT_MAX);
        eligible_s = brResult.valid && brResult.isCondBr && !rst;
        pop_s      = !empty_s && !phtReadBusy;
`ifdef RSD_PHT_QUEUE_COALESCE_EN
        // The newest entry is the one being popped only when it is the sole entry.
        if (eligible_s && !empty_s
            && (entryArray_r[newestPtr_s].index == pushIndex_s)
            && !(pop_s && (count_r == CNT_ONE))) begin
            coalesce_s = 1'b1;
        end else begin
            coalesce_s = 1'b0;
        end
`else
        coalesce_s = 1'b0;
`endif
        push_s = eligible_s && !coalesce_s && (!full_s || pop_s);
        drop_s = eligible_s && !coalesce_s && full_s && !pop_s;
    end

    assign phtWE   = pop_s;
    assign phtWA   = entryArray_r[headPtr_r].index;
    assign phtWV   = entryArray_r[headPtr_r].value;
    assign full    = full_s;
    assign empty   = empty_s;
    assign dropped = drop_s;

    // Head/tail pointers and occupancy count; reset invalidates every entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            headPtr_r <= PTR_ZERO;
            tailPtr_r <= PTR_ZERO;
            count_r   <= CNT_ZERO;
        end else begin
            if (pop_s) begin
                headPtr_r <= headPtr_r + PTR_ONE;
            end else begin
                headPtr_r <= headPtr_r;
            end
            if (push_s) begin
                tailPtr_r <= tailPtr_r + PTR_ONE;
            end else begin
                tailPtr_r <= tailPtr_r;
            end
            count_r <= count_r + QueueCount'(push_s) - QueueCount'(pop_s);
        end
    end

    // Entry storage: new entries at the tail, merged values into the newest slot.
    always_ff @(posedge clk) begin
        if (push_s) begin
            entryArray_r[tailPtr_r] <= '{index: pushIndex_s, value: pushValue_s};
        end
`ifdef RSD_PHT_QUEUE_COALESCE_EN
        else if (coalesce_s) begin
            entryArray_r[newestPtr_s].value <= pushValue_s;
        end
`endif
        else begin
            entryArray_r[tailPtr_r] <= entryArray_r[tailPtr_r];
        end
    end

endmodule

// File: tb/tb_pht_update_queue.sv
// Self-checking bench for pht_update_queue: directed scenarios plus random
// traffic, compared cycle by cycle against a queue-based reference model.
module tb_pht_update_queue;
    import FetchUnitTypes::*;

    localparam int QS = PHT_QUEUE_SIZE;

    logic         clk = 1'b0;
    logic         rst;
    BranchResult  brResult;
    logic         phtReadBusy;
    logic         phtWE;
    PHT_IndexPath phtWA;
    PHT_EntryPath phtWV;
    logic         full;
    logic         empty;
    logic         dropped;

    always #5 clk = ~clk;

    pht_update_queue dut (
        .clk         (clk),
        .rst         (rst),
        .brResult    (brResult),
        .phtReadBusy (phtReadBusy),
        .phtWE       (phtWE),
        .phtWA       (phtWA),
        .phtWV       (phtWV),
        .full        (full),
        .empty       (empty),
        .dropped     (dropped)
    );

    typedef struct { int idx; int val; } ModelEntry;
    ModelEntry mq[$];
    bit        known = 1'b0;
    int        checks = 0;
    int        failures = 0;
    int        writes = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int refIndex(input logic [31:0] addr, input int gh);
        return int'((addr >> 2) & 32'h3FF) ^ gh;
    endfunction

    function automatic int refValue(input int prev, input bit taken);
        if (taken) return (prev >= 3) ? 3 : prev + 1;
        else       return (prev <= 0) ? 0 : prev - 1;
    endfunction

    // One clock cycle: drive inputs, check outputs mid-cycle, advance the model.
    task automatic step(input bit r, input bit v, input bit c, input logic [31:0] addr,
                        input int gh, input int prev, input bit tk, input bit busy);
        int idx, val;
        bit elig, expWe, expDrop, coal;
        @(posedge clk); #1;
        rst                    = r;
        brResult.valid         = v;
        brResult.isCondBr      = c;
        brResult.brAddr        = addr;
        brResult.globalHistory = BranchGlobalHistoryPath'(gh);
        brResult.phtPrevValue  = PHT_EntryPath'(prev);
        brResult.execTaken     = tk;
        phtReadBusy            = busy;
        @(negedge clk);
        elig  = v && c && !r;
        idx   = refIndex(addr, gh);
        val   = refValue(prev, tk);
        expWe = (mq.size() > 0) && !busy;
        coal  = 1'b0;
`ifdef RSD_PHT_QUEUE_COALESCE_EN
        if (elig && mq.size() > 0 && mq[$].idx == idx && !(expWe && mq.size() == 1)) coal = 1'b1;
`endif
        expDrop = elig && !coal && (mq.size() == QS) && !expWe;
        if (known) begin
            chk("empty", empty, 32'(mq.size() == 0));
            chk("full", full, 32'(mq.size() == QS));
            chk("phtWE", phtWE, 32'(expWe));
            chk("dropped", dropped, 32'(expDrop));
            if (expWe) begin
                chk("phtWA", phtWA, 32'(mq[0].idx));
                chk("phtWV", phtWV, 32'(mq[0].val));
            end
        end
        if (phtWE === 1'b1) writes++;
        if (r) begin
            mq.delete();
            known = 1'b1;
        end else begin
            if (expWe) void'(mq.pop_front());
            if (coal) mq[$].val = val;
            else if (elig && !expDrop) mq.push_back('{idx, val});
        end
    endtask

    task automatic idle(input bit busy);
        step(1'b0, 1'b0, 1'b0, 32'h0, 0, 0, 1'b0, busy);
    endtask

    task automatic pushRand(input bit busy);
        step(1'b0, 1'b1, 1'b1, $urandom, int'($urandom_range(0, 1023)),
             int'($urandom_range(0, 3)), 1'(($urandom & 32'h1)), busy);
    endtask

    initial begin
        rst         = 1'b1;
        brResult    = '0;
        phtReadBusy = 1'b0;

        // Reset then idle.
        step(1'b1, 1'b0, 1'b0, 32'h0, 0, 0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 32'h0, 0, 0, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) idle(1'b0);
        chk("idle_empty", empty, 32'd1);
        chk("idle_full", full, 32'd0);

        // Single update: index 0x40, value 2, one-cycle latency.
        step(1'b0, 1'b1, 1'b1, 32'h100, 0, 1, 1'b1, 1'b0);
        chk("single_nobypass_we", phtWE, 32'd0);
        idle(1'b0);
        chk("single_we", phtWE, 32'd1);
        chk("single_wa", phtWA, 32'h40);
        chk("single_wv", phtWV, 32'd2);
        idle(1'b0);
        chk("single_empty_after", empty, 32'd1);

        // Saturation at both ends.
        step(1'b0, 1'b1, 1'b1, 32'h204, 0, 3, 1'b1, 1'b0);
        idle(1'b0);
        chk("sat_hi_wv", phtWV, 32'd3);
        step(1'b0, 1'b1, 1'b1, 32'h208, 0, 0, 1'b0, 1'b0);
        idle(1'b0);
        chk("sat_lo_wv", phtWV, 32'd0);
        idle(1'b0);

        // Ignored results: not valid or not conditional.
        step(1'b0, 1'b0, 1'b1, 32'h300, 0, 1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0, 32'h304, 0, 1, 1'b1, 1'b0);
        idle(1'b0);
        chk("ineligible_empty", empty, 32'd1);

        // Full boundary: 33 pushes under busy, then drain in order.
        for (int i = 1; i <= QS + 1; i++) begin
            step(1'b0, 1'b1, 1'b1, 32'(i * 4 * 7), 0, i % 4, 1'(i % 2), 1'b1);
            if (i == QS + 1) begin
                chk("full_at_33", full, 32'd1);
                chk("drop_at_33", dropped, 32'd1);
            end else begin
                chk("nodrop_before_33", dropped, 32'd0);
            end
        end
        writes = 0;
        for (int i = 0; i < QS; i++) idle(1'b0);
        chk("drain_writes", writes, 32'(QS));
        idle(1'b0);
        chk("drain_empty", empty, 32'd1);

        // Push with pop while full: no drop, occupancy stays at capacity, wraps.
        for (int i = 0; i < QS; i++) pushRand(1'b1);
        for (int i = 0; i < 40; i++) begin
            pushRand(1'b0);
            chk("pushpop_nodrop", dropped, 32'd0);
            chk("pushpop_full", full, 32'd1);
        end
        for (int i = 0; i < QS + 2; i++) idle(1'b0);

        // Mid-operation reset with 5 entries queued, push during reset discarded.
        for (int i = 0; i < 5; i++) pushRand(1'b1);
        step(1'b1, 1'b1, 1'b1, 32'h500, 0, 1, 1'b1, 1'b1);
        idle(1'b0);
        chk("midrst_empty", empty, 32'd1);
        chk("midrst_we", phtWE, 32'd0);

        // Two same-index pushes under busy (merged only with coalescing).
        step(1'b0, 1'b1, 1'b1, 32'h600, 0, 1, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b1, 32'h600, 0, 2, 1'b1, 1'b1);
        writes = 0;
        for (int i = 0; i < 4; i++) idle(1'b0);
`ifdef RSD_PHT_QUEUE_COALESCE_EN
        chk("same_index_writes", writes, 32'd1);
`else
        chk("same_index_writes", writes, 32'd2);
`endif

        // Random traffic with a narrow address space so indices collide.
        for (int i = 0; i < 600; i++) begin
            bit busy;
            logic [31:0] addr;
            busy = (i < 300) ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 2) == 0);
            addr = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 3) * 4) : $urandom;
            step(1'($urandom_range(0, 149) == 0), 1'($urandom & 32'h1), 1'($urandom_range(0, 3) != 0),
                 addr, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                 1'($urandom & 32'h1), busy);
        end
        for (int i = 0; i < QS + 2; i++) idle(1'b0);
        chk("final_empty", empty, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
